// File: rtl/aes_pkg.sv
// Shared AES constants and types used by the key schedule and the cipher.
// Holds the forward S-box, the round constants, the word/block typedefs and the schedule FSM states.
package aes_pkg;

    localparam int NB = 4;

    typedef logic [0:31]  word_t;
    typedef logic [0:127] block_t;

    typedef enum logic {IDLE, EXPAND} state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant with out-of-table indices folded to zero.
    function automatic logic [7:0] rcon_f(input int i);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            if (i == k) r = RCON[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box byte lookup, shared by the key schedule and the cipher.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative FIPS-197 key schedule: one schedule word per clock into a register array,
// with a combinational 128-bit round-key read port for the downstream cipher.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [0:NK*32-1] key,
    output logic           busy,
    output logic           done,
    input  logic [3:0]     rk_rd_addr,
    output logic [0:127]   rk_rd_data
);

    localparam int NKB   = NK * 32;
    localparam int NW    = 4 * (NR + 1);
    localparam int IDX_W = $clog2(NW + 1);

    state_e state, state_next;
    logic [IDX_W-1:0] idx;
    word_t w [0:NW-1];

    logic [IDX_W-1:0] prev_idx, old_idx, rd_base;
    word_t prev, sub_in, sub_out, temp, new_word;
    logic at_rot, at_sub, last;
    int idx_i;

    assign idx_i    = int'(idx);
    assign at_rot   = (idx_i % NK) == 0;
    assign at_sub   = (NK == 8) && ((idx_i % NK) == 4);
    assign last     = (idx == IDX_W'(NW - 1));
    // Guard the look-back indices so IDLE-time reads stay inside the array.
    assign prev_idx = (idx == '0) ? '0 : idx - IDX_W'(1);
    assign old_idx  = (idx >= IDX_W'(NK)) ? idx - IDX_W'(NK) : '0;
    assign prev     = w[prev_idx];
    assign sub_in   = at_rot ? {prev[8:31], prev[0:7]} : prev;

    // One SubWord datapath serves both the RotWord and the AES-256 mid-key case.
    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a (sub_in[8*g +: 8]),
            .y (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (at_rot)
            temp = sub_out ^ {rcon_f(idx_i / NK), 24'h0};
        else if (at_sub)
            temp = sub_out;
        new_word = w[old_idx] ^ temp;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EXPAND;
            EXPAND:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            idx   <= '0;
            for (int k = 0; k < NW; k++) w[k] <= '0;
        end else begin
            state <= state_next;
            done  <= (state == EXPAND) && last;
            if (state == IDLE && start) begin
                for (int k = 0; k < NK; k++) w[k] <= key[32*k +: 32];
                idx <= IDX_W'(NK);
            end else if (state == EXPAND) begin
                w[idx] <= new_word;
                idx    <= idx + IDX_W'(1);
            end
        end
    end

    assign busy    = (state == EXPAND);
    assign rd_base = IDX_W'({rk_rd_addr, 2'b00});

    always_comb begin
        rk_rd_data = '0;
        if (rk_rd_addr <= 4'(NR))
            rk_rd_data = {w[rd_base], w[rd_base + IDX_W'(1)],
                          w[rd_base + IDX_W'(2)], w[rd_base + IDX_W'(3)]};
    end

    logic unused_nkb;
    assign unused_nkb = (NKB == 0);

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for the AES-128/192/256 key schedules against FIPS-197 vectors.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           start128, start192, start256;
    logic [0:127]   key128;
    logic [0:191]   key192;
    logic [0:255]   key256;
    logic           busy128, busy192, busy256;
    logic           done128, done192, done256;
    logic [3:0]     addr128, addr192, addr256;
    logic [0:127]   data128, data192, data256;

    aes_key_expand #(.NK(4), .NR(10)) u128 (
        .clk(clk), .rst_n(rst_n), .start(start128), .key(key128),
        .busy(busy128), .done(done128), .rk_rd_addr(addr128), .rk_rd_data(data128));
    aes_key_expand #(.NK(6), .NR(12)) u192 (
        .clk(clk), .rst_n(rst_n), .start(start192), .key(key192),
        .busy(busy192), .done(done192), .rk_rd_addr(addr192), .rk_rd_data(data192));
    aes_key_expand #(.NK(8), .NR(14)) u256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .key(key256),
        .busy(busy256), .done(done256), .rk_rd_addr(addr256), .rk_rd_data(data256));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd128(input logic [3:0] r, output logic [127:0] d);
        addr128 = r;
        #1;
        d = data128;
    endtask

    localparam logic [0:127] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] R12_6 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R14_8 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic [127:0] d;
    int first_done, second_done, n_done;
    logic all_zero;

    initial begin
        rst_n = 1'b0;
        start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
        key128 = K128;
        key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        addr128 = '0; addr192 = '0; addr256 = '0;
        #23;
        check("reset_busy", 128'(busy128), 128'd0);
        check("reset_done", 128'(done128), 128'd0);
        rd128(4'd0, d); check("reset_round0", d, 128'd0);
        rst_n = 1'b1;
        tick();

        // All three widths together; a second start on the 128-bit unit mid-run must be ignored.
        start128 = 1'b1; start192 = 1'b1; start256 = 1'b1;
        tick();
        start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
        check("busy_after_start", 128'(busy128), 128'd1);
        key128 = '1;
        first_done = 0; n_done = 0;
        for (int e = 2; e <= 60; e++) begin
            if (e == 10) start128 = 1'b1;
            tick();
            start128 = 1'b0;
            if (done128) begin
                n_done++;
                if (first_done == 0) first_done = e;
            end
        end
        check("done_edge_128", 128'(first_done), 128'd41);
        check("done_count_128", 128'(n_done), 128'd1);
        check("busy_after_done", 128'(busy128), 128'd0);
        rd128(4'd0, d);  check("aes128_round0", d, K128);
        rd128(4'd1, d);  check("aes128_round1", d, R1);
        rd128(4'd10, d); check("aes128_round10", d, R10);
        rd128(4'd11, d); check("aes128_addr_oob", d, 128'd0);
        addr192 = 4'd12; addr256 = 4'd14;
        #1;
        check("aes192_round12", data192, R12_6);
        check("aes256_round14", data256, R14_8);
        addr256 = 4'd15;
        #1;
        check("aes256_addr_oob", data256, 128'd0);

        // All-zero key.
        key128 = '0;
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        for (int e = 2; e <= 45; e++) tick();
        rd128(4'd0, d); check("zero_round0", d, 128'd0);
        rd128(4'd1, d); check("zero_round1", d, Z1);

        // Start held high across done: restart is taken on the done cycle with the key present then.
        start128 = 1'b1;
        tick();
        first_done = 0; second_done = 0; n_done = 0;
        for (int e = 2; e <= 90; e++) begin
            tick();
            if (e == 41) key128 = K128;
            if (e == 42) start128 = 1'b0;
            if (done128) begin
                n_done++;
                if (first_done == 0) first_done = e;
                else if (second_done == 0) second_done = e;
            end
        end
        check("held_first_done", 128'(first_done), 128'd41);
        check("held_second_done", 128'(second_done), 128'd82);
        check("held_done_count", 128'(n_done), 128'd2);
        rd128(4'd10, d); check("held_round10", d, R10);

        // Reset in the middle of an expansion.
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy128), 128'd0);
        check("midrst_done", 128'(done128), 128'd0);
        all_zero = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            rd128(4'(r), d);
            if (d != '0) all_zero = 1'b0;
        end
        check("midrst_rounds_zero", 128'(all_zero), 128'd1);
        #5;
        rst_n = 1'b1;
        tick();
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        n_done = 0;
        for (int e = 2; e <= 45; e++) begin
            tick();
            if (done128) n_done++;
        end
        check("rerun_done_count", 128'(n_done), 128'd1);
        rd128(4'd1, d);  check("rerun_round1", d, R1);
        rd128(4'd10, d); check("rerun_round10", d, R10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
